// File: rtl/mips_controller_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// master = controller (decodes IR fields, drives controls); slave = datapath.
interface mips_controller_if;
    logic [5:0] OPC;
    logic [5:0] Func;
    logic       zero;

    logic       PCsel;
    logic [1:0] PCSrc;
    logic       Jrsel;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       sel31;
    logic       MemToReg;
    logic       selPc;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALU_operation;
    logic       illegal;

    modport master (
        input  OPC, Func, zero,
        output PCsel, PCSrc, Jrsel, IorD, MemRead, MemWrite, IRWrite, RegDst,
               sel31, MemToReg, selPc, RegWrite, ALUSrcA, ALUSrcB, ALU_operation, illegal
    );

    modport slave (
        output OPC, Func, zero,
        input  PCsel, PCSrc, Jrsel, IorD, MemRead, MemWrite, IRWrite, RegDst,
               sel31, MemToReg, selPc, RegWrite, ALUSrcA, ALUSrcB, ALU_operation, illegal
    );
endinterface

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: one instruction step per clk, no overlap.
// Optional build macro MIPS_CTRL_BNE_EN adds bne (OPC 000101) as a branch with inverted zero test.
//
// state  | meaning
// FETCH  | read instruction, load IR, PC <= PC + 4
// DECODE | branch target into ALUOut, dispatch on OPC
// REX    | R-type ALU operation
// RWB    | R-type write back to rd
// IEX    | addi/slti ALU operation
// IWB    | immediate write back to rt
// MADR   | lw/sw effective address
// MRD    | lw memory read
// MWB    | lw write back from MDR
// MWR    | sw memory write
// BRANCH | beq (bne) compare, conditional PC load from ALUOut
// JMP    | j: PC <= jump target
// JAL    | jal: PC <= jump target, r31 <= PC
// JR     | jr: PC <= A
module mips_controller (
    input  logic              clk,
    input  logic              rst,
    mips_controller_if.master ctrl
);
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH, DECODE, REX, RWB, IEX, IWB, MADR, MRD, MWB, MWR, BRANCH, JMP, JAL, JR
    } state_t;

    state_t state;
    logic   run;
    logic   active;
    logic   opc_ok;
    logic   func_ok;
    logic   take_branch;
    logic [2:0] rex_op;

    // run holds the FSM in FETCH for the cycle in which reset is released, so the
    // first FETCH executes in the cycle after rst is first sampled high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                case (state)
                    FETCH:  state <= DECODE;
                    DECODE: begin
                        case (ctrl.OPC)
                            OP_RTYPE:        state <= (ctrl.Func == FN_JR) ? JR : REX;
                            OP_LW, OP_SW:    state <= MADR;
                            OP_BEQ:          state <= BRANCH;
`ifdef MIPS_CTRL_BNE_EN
                            OP_BNE:          state <= BRANCH;
`endif
                            OP_ADDI, OP_SLTI: state <= IEX;
                            OP_J:            state <= JMP;
                            OP_JAL:          state <= JAL;
                            default:         state <= FETCH;
                        endcase
                    end
                    REX:     state <= func_ok ? RWB : FETCH;
                    IEX:     state <= IWB;
                    MADR:    state <= (ctrl.OPC == OP_LW) ? MRD : MWR;
                    MRD:     state <= MWB;
                    default: state <= FETCH;
                endcase
            end
        end
    end

    assign active = rst && run;

    always_comb begin
        opc_ok = 1'b0;
        case (ctrl.OPC)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J, OP_JAL: opc_ok = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE: opc_ok = 1'b1;
`endif
            default: opc_ok = 1'b0;
        endcase
    end

    always_comb begin
        func_ok = 1'b1;
        rex_op  = ALU_ADD;
        case (ctrl.Func)
            FN_ADD:  rex_op = ALU_ADD;
            FN_SUB:  rex_op = ALU_SUB;
            FN_AND:  rex_op = ALU_AND;
            FN_OR:   rex_op = ALU_OR;
            FN_SLT:  rex_op = ALU_SLT;
            default: func_ok = 1'b0;
        endcase
    end

`ifdef MIPS_CTRL_BNE_EN
    assign take_branch = (ctrl.OPC == OP_BNE) ? !ctrl.zero : ctrl.zero;
`else
    assign take_branch = ctrl.zero;
`endif

    always_comb begin
        ctrl.PCsel         = 1'b0;
        ctrl.PCSrc         = 2'b00;
        ctrl.Jrsel         = 1'b0;
        ctrl.IorD          = 1'b0;
        ctrl.MemRead       = 1'b0;
        ctrl.MemWrite      = 1'b0;
        ctrl.IRWrite       = 1'b0;
        ctrl.RegDst        = 1'b0;
        ctrl.sel31         = 1'b0;
        ctrl.MemToReg      = 1'b0;
        ctrl.selPc         = 1'b0;
        ctrl.RegWrite      = 1'b0;
        ctrl.ALUSrcA       = 1'b0;
        ctrl.ALUSrcB       = 2'b00;
        ctrl.ALU_operation = ALU_ADD;
        ctrl.illegal       = 1'b0;
        if (active) begin
            case (state)
                FETCH: begin
                    ctrl.MemRead = 1'b1;
                    ctrl.IRWrite = 1'b1;
                    ctrl.ALUSrcB = 2'b01;
                    ctrl.PCsel   = 1'b1;
                end
                DECODE: begin
                    ctrl.ALUSrcB = 2'b11;
                    ctrl.illegal = !opc_ok;
                end
                REX: begin
                    ctrl.ALUSrcA       = 1'b1;
                    ctrl.ALU_operation = rex_op;
                    ctrl.illegal       = !func_ok;
                end
                RWB: begin
                    ctrl.RegDst   = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                IEX: begin
                    ctrl.ALUSrcA       = 1'b1;
                    ctrl.ALUSrcB       = 2'b10;
                    ctrl.ALU_operation = (ctrl.OPC == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                IWB: ctrl.RegWrite = 1'b1;
                MADR: begin
                    ctrl.ALUSrcA = 1'b1;
                    ctrl.ALUSrcB = 2'b10;
                end
                MRD: begin
                    ctrl.IorD    = 1'b1;
                    ctrl.MemRead = 1'b1;
                end
                MWB: begin
                    ctrl.MemToReg = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                MWR: begin
                    ctrl.IorD     = 1'b1;
                    ctrl.MemWrite = 1'b1;
                end
                BRANCH: begin
                    ctrl.ALUSrcA       = 1'b1;
                    ctrl.ALU_operation = ALU_SUB;
                    ctrl.PCSrc         = 2'b10;
                    ctrl.PCsel         = take_branch;
                end
                JMP: begin
                    ctrl.PCSrc = 2'b01;
                    ctrl.PCsel = 1'b1;
                end
                JAL: begin
                    ctrl.PCSrc    = 2'b01;
                    ctrl.PCsel    = 1'b1;
                    ctrl.sel31    = 1'b1;
                    ctrl.selPc    = 1'b1;
                    ctrl.RegWrite = 1'b1;
                end
                JR: begin
                    ctrl.Jrsel = 1'b1;
                    ctrl.PCsel = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: per-instruction step lists from the ISA rules,
// expected control words per step, compared against the DUT every cycle.
module tb_mips_controller;
    typedef struct packed {
        logic       PCsel;
        logic [1:0] PCSrc;
        logic       Jrsel;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       sel31;
        logic       MemToReg;
        logic       selPc;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALU_operation;
        logic       illegal;
    } ctrl_t;

    typedef enum {
        S_OFF, S_FETCH, S_DECODE, S_REX, S_RWB, S_IEX, S_IWB, S_MADR, S_MRD, S_MWB,
        S_MWR, S_BRANCH, S_JMP, S_JAL, S_JR
    } step_e;

`ifdef MIPS_CTRL_BNE_EN
    localparam bit BNE_ON  = 1'b1;
    localparam int BNE_LEN = 3;
`else
    localparam bit BNE_ON  = 1'b0;
    localparam int BNE_LEN = 2;
`endif

    logic clk;
    logic rst;
    mips_controller_if cif ();

    mips_controller dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (cif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_pass  = 0;
    int    n_total = 0;
    step_e steps[$];
    logic  run_m   = 1'b0;
    logic [5:0] cur_opc  = 6'd0;
    logic [5:0] cur_func = 6'd0;
    ctrl_t exp_c;
    step_e exp_step  = S_OFF;
    bit    exp_valid = 1'b0;

    // ALU code for a supported R-type function, -1 when the function is not supported
    function automatic int rfunc_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 2;
            6'h22:   return 6;
            6'h24:   return 0;
            6'h25:   return 1;
            6'h2a:   return 7;
            default: return -1;
        endcase
    endfunction

    function automatic bit opc_known(input logic [5:0] opc);
        if (opc == 6'h05) return BNE_ON;
        return opc inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0a, 6'h02, 6'h03};
    endfunction

    function automatic ctrl_t idle_ctrl();
        ctrl_t c = '0;
        c.ALU_operation = 3'b010;
        return c;
    endfunction

    function automatic ctrl_t expect_ctrl(input step_e s, input logic [5:0] opc,
                                          input logic [5:0] fn, input logic z);
        ctrl_t c = idle_ctrl();
        case (s)
            S_FETCH:  begin c.MemRead = 1; c.IRWrite = 1; c.ALUSrcB = 2'b01; c.PCsel = 1; end
            S_DECODE: begin c.ALUSrcB = 2'b11; c.illegal = !opc_known(opc); end
            S_REX: begin
                c.ALUSrcA = 1;
                if (rfunc_alu(fn) < 0) c.illegal = 1;
                else c.ALU_operation = 3'(rfunc_alu(fn));
            end
            S_RWB:    begin c.RegDst = 1; c.RegWrite = 1; end
            S_IEX: begin
                c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
                c.ALU_operation = (opc == 6'h0a) ? 3'b111 : 3'b010;
            end
            S_IWB:    c.RegWrite = 1;
            S_MADR:   begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            S_MRD:    begin c.IorD = 1; c.MemRead = 1; end
            S_MWB:    begin c.MemToReg = 1; c.RegWrite = 1; end
            S_MWR:    begin c.IorD = 1; c.MemWrite = 1; end
            S_BRANCH: begin
                c.ALUSrcA = 1; c.ALU_operation = 3'b110; c.PCSrc = 2'b10;
                c.PCsel = (opc == 6'h05) ? !z : z;
            end
            S_JMP:    begin c.PCSrc = 2'b01; c.PCsel = 1; end
            S_JAL:    begin c.PCSrc = 2'b01; c.PCsel = 1; c.sel31 = 1; c.selPc = 1; c.RegWrite = 1; end
            S_JR:     begin c.Jrsel = 1; c.PCsel = 1; end
            default:  ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t dut_ctrl();
        ctrl_t c;
        c.PCsel = cif.PCsel;       c.PCSrc = cif.PCSrc;       c.Jrsel = cif.Jrsel;
        c.IorD = cif.IorD;         c.MemRead = cif.MemRead;   c.MemWrite = cif.MemWrite;
        c.IRWrite = cif.IRWrite;   c.RegDst = cif.RegDst;     c.sel31 = cif.sel31;
        c.MemToReg = cif.MemToReg; c.selPc = cif.selPc;       c.RegWrite = cif.RegWrite;
        c.ALUSrcA = cif.ALUSrcA;   c.ALUSrcB = cif.ALUSrcB;   c.ALU_operation = cif.ALU_operation;
        c.illegal = cif.illegal;
        return c;
    endfunction

    always @(negedge clk) begin
        #2;
        if (exp_valid) begin
            ctrl_t got;
            got = dut_ctrl();
            n_total++;
            if (got === exp_c) n_pass++;
            else $display("FAIL ctrl[%s] opc=%b func=%b zero=%b got=%05h exp=%05h",
                          exp_step.name(), cur_opc, cur_func, cif.zero, got, exp_c);
        end
    end

    task automatic check_len(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL len_%s got=%0d exp=%0d", name, got, want);
    endtask

    task automatic load(input logic [5:0] opc, input logic [5:0] fn);
        steps.delete();
        cur_opc  = opc;
        cur_func = fn;
        steps.push_back(S_FETCH);
        steps.push_back(S_DECODE);
        if (opc == 6'h00) begin
            if (fn == 6'h08) steps.push_back(S_JR);
            else begin
                steps.push_back(S_REX);
                if (rfunc_alu(fn) >= 0) steps.push_back(S_RWB);
            end
        end else if (opc == 6'h23) begin
            steps.push_back(S_MADR); steps.push_back(S_MRD); steps.push_back(S_MWB);
        end else if (opc == 6'h2b) begin
            steps.push_back(S_MADR); steps.push_back(S_MWR);
        end else if (opc == 6'h04 || (opc == 6'h05 && BNE_ON)) begin
            steps.push_back(S_BRANCH);
        end else if (opc == 6'h08 || opc == 6'h0a) begin
            steps.push_back(S_IEX); steps.push_back(S_IWB);
        end else if (opc == 6'h02) steps.push_back(S_JMP);
        else if (opc == 6'h03) steps.push_back(S_JAL);
    endtask

    // One clock: drive inputs at negedge, publish expectation, advance model at posedge.
    task automatic tick(input logic r, input int zmode);
        @(negedge clk);
        rst      = r;
        cif.OPC  = cur_opc;
        cif.Func = cur_func;
        cif.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
        if (r && run_m && steps.size() > 0) begin
            exp_c    = expect_ctrl(steps[0], cur_opc, cur_func, cif.zero);
            exp_step = steps[0];
        end else begin
            exp_c    = idle_ctrl();
            exp_step = S_OFF;
        end
        exp_valid = 1'b1;
        @(posedge clk);
        exp_valid = 1'b0;
        if (!r) steps.delete();
        else if (run_m && steps.size() > 0) void'(steps.pop_front());
        run_m = r;
    endtask

    task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn, input int zmode,
                             input int want_len, input string name, input bit rnd_rst);
        load(opc, fn);
        if (want_len > 0) check_len(name, steps.size(), want_len);
        for (int g = 0; g < 20 && steps.size() > 0; g++)
            tick(rnd_rst ? ($urandom_range(0, 59) != 0) : 1'b1, zmode);
    endtask

    initial begin
        rst = 1'b0;
        cif.OPC = '0; cif.Func = '0; cif.zero = 1'b0;
        tick(1'b0, 2);
        tick(1'b0, 2);

        run_instr(6'h00, 6'h20, 2, 4, "add", 0);
        run_instr(6'h23, 6'h00, 2, 5, "lw", 0);
        run_instr(6'h2b, 6'h11, 2, 4, "sw", 0);
        run_instr(6'h08, 6'h00, 2, 4, "addi", 0);
        run_instr(6'h0a, 6'h00, 2, 4, "slti", 0);
        run_instr(6'h04, 6'h00, 1, 3, "beq_z1", 0);
        run_instr(6'h04, 6'h00, 0, 3, "beq_z0", 0);
        run_instr(6'h02, 6'h00, 2, 3, "j", 0);
        run_instr(6'h03, 6'h00, 2, 3, "jal", 0);
        run_instr(6'h00, 6'h08, 2, 3, "jr", 0);
        run_instr(6'h3f, 6'h00, 2, 2, "bad_opc", 0);
        run_instr(6'h00, 6'h07, 2, 3, "bad_func", 0);
        run_instr(6'h05, 6'h00, 1, BNE_LEN, "bne_z1", 0);
        run_instr(6'h05, 6'h00, 0, BNE_LEN, "bne_z0", 0);

        // abort a lw in its memory-read step with a two-cycle reset
        load(6'h23, 6'h00);
        for (int g = 0; g < 10 && steps.size() > 0 && steps[0] != S_MRD; g++) tick(1'b1, 2);
        tick(1'b0, 2);
        tick(1'b0, 2);
        run_instr(6'h00, 6'h22, 2, 4, "sub_after_rst", 0);

        for (int n = 0; n < 300; n++) begin
            logic [5:0] opc;
            logic [5:0] fn;
            fn = 6'($urandom);
            case ($urandom_range(0, 15))
                0:  opc = 6'h23;
                1:  opc = 6'h2b;
                2, 3: begin opc = 6'h00; fn = (fn[0]) ? 6'h20 : 6'h2a; end
                4:  begin opc = 6'h00; fn = (fn[0]) ? 6'h24 : 6'h25; end
                5:  begin opc = 6'h00; fn = 6'h22; end
                6:  opc = 6'h08;
                7:  opc = 6'h0a;
                8:  opc = 6'h04;
                9:  opc = 6'h05;
                10: opc = 6'h02;
                11: opc = 6'h03;
                12: begin opc = 6'h00; fn = 6'h08; end
                13: opc = 6'h00;
                default: opc = 6'($urandom);
            endcase
            run_instr(opc, fn, 2, 0, "rnd", 1);
        end

        @(negedge clk);
        #5;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
